// File: rtl/mkmif_arbiter.sv
// mkmif_arbiter: two-client round-robin arbiter and op sequencer
// in front of the Master Key Memory interface core.
module mkmif_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        c0_req,
  input  logic        c0_we,
  input  logic [10:0] c0_addr,
  input  logic [31:0] c0_wdata,
  output logic        c0_ack,
  output logic        c0_err,
  output logic [31:0] c0_rdata,

  input  logic        c1_req,
  input  logic        c1_we,
  input  logic [10:0] c1_addr,
  input  logic [31:0] c1_wdata,
  output logic        c1_ack,
  output logic        c1_err,
  output logic [31:0] c1_rdata,

  output logic        busy,

  output logic        core_read_op,
  output logic        core_write_op,
  output logic [10:0] core_addr,
  output logic [31:0] core_write_data,
  input  logic        core_ready,
  input  logic        core_valid,
  input  logic [31:0] core_read_data
);

  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        ptr;
  logic        sel;
  logic        we_q;
  logic        err_q;
  logic [15:0] cnt;

  logic        grant;
  logic        accept;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        err_set;
  logic        rd_cap;
  logic        resp;

  // pick the winner: pointer breaks ties, else the lone requester
  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (c0_req && c1_req): grant = ptr;
      (c0_req ^ c1_req):  grant = c1_req;
      default:            grant = ptr;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    err_set   = 1'b0;
    rd_cap    = 1'b0;
    resp      = 1'b0;
    unique case (state)
      IDLE: begin
        if (core_ready && (c0_req || c1_req)) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_clr   = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!core_ready) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == TO_LAST) begin
          err_set   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        // no timeout: op length scales with the SPI divider
        if (core_ready) begin
          state_nxt = RESP;
          if (!we_q) begin
            rd_cap  = 1'b1;
            err_set = !core_valid;
          end
        end
      end
      RESP: begin
        resp      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // request latch, timeout counter, error flag, pointer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr             <= 1'b0;
      sel             <= 1'b0;
      we_q            <= 1'b0;
      err_q           <= 1'b0;
      cnt             <= '0;
      core_addr       <= '0;
      core_write_data <= '0;
    end else begin
      if (accept) begin
        sel <= grant;
        if (grant) begin
          we_q            <= c1_we;
          core_addr       <= c1_addr;
          core_write_data <= c1_wdata;
        end else begin
          we_q            <= c0_we;
          core_addr       <= c0_addr;
          core_write_data <= c0_wdata;
        end
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 16'd1;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (resp) begin
        err_q <= 1'b0;
      end
      if (resp) begin
        ptr <= !sel;
      end
    end
  end

  // per-client read data, only the granted client's copy moves
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c0_rdata <= '0;
      c1_rdata <= '0;
    end else if (rd_cap) begin
      if (sel) begin
        c1_rdata <= core_read_data;
      end else begin
        c0_rdata <= core_read_data;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign core_read_op  = (state == ISSUE) && !we_q;
  assign core_write_op = (state == ISSUE) && we_q;
  assign c0_ack        = resp && !sel;
  assign c1_ack        = resp && sel;
  assign c0_err        = c0_ack && err_q;
  assign c1_err        = c1_ack && err_q;

endmodule
